// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared types, limits and BCD helpers for the clock time-set controller
//
// Purpose : BCD digit type, controller state encoding, HH:MM limits and
//           wrap-around increment helpers for hours (00..23) and minutes (00..59).
// Ports   : none (package).

package clock_ctrl_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_H  = 2'd1,
        SET_M  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam bcd_t MAX_HORA_D      = 4'd2;
    localparam bcd_t MAX_HORA_U_AT_2 = 4'd3;
    localparam bcd_t MAX_MIN_D       = 4'd5;

    // Returns {tens, units}; 23 wraps to 00, x9 carries into the tens digit.
    function automatic logic [7:0] bcd_hours_inc(input bcd_t d, input bcd_t u);
        logic [7:0] r;
        if (d == MAX_HORA_D && u == MAX_HORA_U_AT_2) begin
            r = 8'h00;
        end else if (u == 4'd9) begin
            r = {d + 4'd1, 4'd0};
        end else begin
            r = {d, u + 4'd1};
        end
        return r;
    endfunction

    // Returns {tens, units}; 59 wraps to 00 with no carry out.
    function automatic logic [7:0] bcd_mins_inc(input bcd_t d, input bcd_t u);
        logic [7:0] r;
        if (u == 4'd9) begin
            r = (d == MAX_MIN_D) ? 8'h00 : {d + 4'd1, 4'd0};
        end else begin
            r = {d, u + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and rising-edge press detector
//
// Purpose : 2-flop synchroniser, stability counter and registered edge detect.
//           A clean raw rise yields press DEBOUNCE_CYC+3 cycles later.
// Ports   : clk, reset (sync, active-high), btn (raw async level),
//           level (debounced level), press (1-cycle pulse on debounced rise).

module btn_debounce #(
    parameter int DEBOUNCE_CYC = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync0;
    logic          sync1;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync0   <= btn;
            sync1   <= sync0;
            level_q <= level;
            press   <= level & ~level_q;
            // Any sample that agrees with the current level restarts the
            // stability window, so short glitches never reach level.
            if (sync1 != level) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    level <= sync1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - HH:MM time-set controller driven by mode/inc push buttons
//
// Purpose : Captures the running time, lets the user edit hours then minutes,
//           and commits the result to the clock counter with a 1-cycle load.
//           Abandons the edit after TIMEOUT_S idle seconds. Drives digit blink.
// Ports   : clk, reset (sync, active-high), btn_mode, btn_inc (raw buttons),
//           cur_hora_d/u, cur_min_d/u (running time, BCD),
//           load, set_hora_d/u, set_min_d/u (preset strobe and value),
//           setting (counter freeze), blink_hours, blink_mins (display blanking).
// Config  : AUTO_REPEAT_EN - holding inc repeats the increment every
//           REPEAT_RATE cycles after REPEAT_DELAY cycles.

module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 2000,
    parameter int TICK_DIV     = 100000,
    parameter int TIMEOUT_S    = 10,
    parameter int BLINK_DIV    = 50000,
    parameter int REPEAT_DELAY = 50000,
    parameter int REPEAT_RATE  = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hora_d,
    input  logic [3:0] cur_hora_u,
    input  logic [3:0] cur_min_d,
    input  logic [3:0] cur_min_u,
    output logic       load,
    output logic [3:0] set_hora_d,
    output logic [3:0] set_hora_u,
    output logic [3:0] set_min_d,
    output logic [3:0] set_min_u,
    output logic       setting,
    output logic       blink_hours,
    output logic       blink_mins
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int SW = $clog2(TIMEOUT_S + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    state_t        state, state_n;
    logic          mode_p, inc_p, mode_lvl, inc_lvl, inc_any;
    logic          capture, inc_h, inc_m, in_set, timeout, enter_set;
    logic          time_ok;
    bcd_t          sh_hd, sh_hu, sh_md, sh_mu;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] sec_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .level (mode_lvl),
        .press (mode_p)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_inc),
        .level (inc_lvl),
        .press (inc_p)
    );

    assign in_set = (state == SET_H) || (state == SET_M);

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_armed;
    logic          rep_p;
    logic          unused_lvl;

    assign unused_lvl = mode_lvl;

    // First repeat after REPEAT_DELAY held cycles, then one every REPEAT_RATE.
    always_ff @(posedge clk) begin
        if (reset || !inc_lvl || !in_set) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_p     <= 1'b0;
        end else begin
            rep_p <= 1'b0;
            if (!rep_armed) begin
                if (rep_cnt == RW'(REPEAT_DELAY - 1)) begin
                    rep_armed <= 1'b1;
                    rep_cnt   <= '0;
                    rep_p     <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end else if (rep_cnt == RW'(REPEAT_RATE - 1)) begin
                rep_cnt <= '0;
                rep_p   <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + RW'(1);
            end
        end
    end

    assign inc_any = inc_p | rep_p;
`else
    localparam int unused_repeat = REPEAT_DELAY + REPEAT_RATE;
    logic [1:0] unused_lvl;

    assign unused_lvl = {mode_lvl, inc_lvl};
    assign inc_any    = inc_p;
`endif

    // Out-of-range captures (including non-BCD digits) restart the edit at 00:00.
    assign time_ok = (cur_hora_u <= 4'd9) && (cur_min_u <= 4'd9) &&
                     (cur_min_d <= MAX_MIN_D) &&
                     ((cur_hora_d < MAX_HORA_D) ||
                      (cur_hora_d == MAX_HORA_D && cur_hora_u <= MAX_HORA_U_AT_2));

    assign timeout = in_set && (tick_cnt == TW'(TICK_DIV - 1)) &&
                     (sec_cnt == SW'(TIMEOUT_S - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    // Mode is checked before inc in every state, so a simultaneous inc is dropped.
    always_comb begin
        state_n = state;
        capture = 1'b0;
        inc_h   = 1'b0;
        inc_m   = 1'b0;
        load    = 1'b0;
        setting = 1'b0;
        case (state)
            RUN: begin
                if (mode_p) begin
                    state_n = SET_H;
                    capture = 1'b1;
                end
            end
            SET_H: begin
                setting = 1'b1;
                if (mode_p)       state_n = SET_M;
                else if (inc_any) inc_h   = 1'b1;
                else if (timeout) state_n = RUN;
            end
            SET_M: begin
                setting = 1'b1;
                if (mode_p)       state_n = COMMIT;
                else if (inc_any) inc_m   = 1'b1;
                else if (timeout) state_n = RUN;
            end
            COMMIT: begin
                load    = 1'b1;
                state_n = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    assign enter_set   = (state_n != state) && ((state_n == SET_H) || (state_n == SET_M));
    assign blink_hours = (state == SET_H) && phase;
    assign blink_mins  = (state == SET_M) && phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_hd      <= '0;
            sh_hu      <= '0;
            sh_md      <= '0;
            sh_mu      <= '0;
            set_hora_d <= '0;
            set_hora_u <= '0;
            set_min_d  <= '0;
            set_min_u  <= '0;
            tick_cnt   <= '0;
            sec_cnt    <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
        end else begin
            if (capture) begin
                if (time_ok) begin
                    {sh_hd, sh_hu, sh_md, sh_mu} <= {cur_hora_d, cur_hora_u, cur_min_d, cur_min_u};
                end else begin
                    {sh_hd, sh_hu, sh_md, sh_mu} <= '0;
                end
            end else if (inc_h) begin
                {sh_hd, sh_hu} <= bcd_hours_inc(sh_hd, sh_hu);
            end else if (inc_m) begin
                {sh_md, sh_mu} <= bcd_mins_inc(sh_md, sh_mu);
            end

            // Shadow cannot change on the SET_M->COMMIT edge, so this is the committed time.
            if (state_n == COMMIT) begin
                {set_hora_d, set_hora_u, set_min_d, set_min_u} <= {sh_hd, sh_hu, sh_md, sh_mu};
            end

            if (!in_set || mode_p || inc_any) begin
                tick_cnt <= '0;
                sec_cnt  <= '0;
            end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
                tick_cnt <= '0;
                sec_cnt  <= sec_cnt + SW'(1);
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end

            if (enter_set) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed self-checking bench for clock_set_ctrl

module tb_clock_set_ctrl;

    localparam int DEBOUNCE_CYC = 4;
    localparam int TICK_DIV     = 10;
    localparam int TIMEOUT_S    = 3;
    localparam int BLINK_DIV    = 5;
    localparam int REPEAT_DELAY = 20;
    localparam int REPEAT_RATE  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_hora_d, cur_hora_u, cur_min_d, cur_min_u;
    logic       load;
    logic [3:0] set_hora_d, set_hora_u, set_min_d, set_min_u;
    logic       setting;
    logic       blink_hours;
    logic       blink_mins;

    int          checks = 0;
    int          errors = 0;
    int          load_cnt = 0;
    logic [15:0] load_val = 16'h0;
    int          lc;

    clock_set_ctrl #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .TICK_DIV     (TICK_DIV),
        .TIMEOUT_S    (TIMEOUT_S),
        .BLINK_DIV    (BLINK_DIV),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .cur_hora_d  (cur_hora_d),
        .cur_hora_u  (cur_hora_u),
        .cur_min_d   (cur_min_d),
        .cur_min_u   (cur_min_u),
        .load        (load),
        .set_hora_d  (set_hora_d),
        .set_hora_u  (set_hora_u),
        .set_min_d   (set_min_d),
        .set_min_u   (set_min_u),
        .setting     (setting),
        .blink_hours (blink_hours),
        .blink_mins  (blink_mins)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt = load_cnt + 1;
            load_val = {set_hora_d, set_hora_u, set_min_d, set_min_u};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ends 1 time unit after the n-th following negedge (n rising edges elapsed).
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        tick(8);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick(8);
    endtask

    task automatic set_cur(input logic [15:0] t);
        {cur_hora_d, cur_hora_u, cur_min_d, cur_min_u} = t;
    endtask

    task automatic commit_expect(input string tag, input logic [15:0] exp);
        lc = load_cnt;
        press(1'b1, 1'b0);
        check({tag, " load_cycles"}, load_cnt - lc, 1);
        check({tag, " set"}, load_val, exp);
    endtask

    initial begin
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        set_cur(16'h0000);
        tick(3);
        check("rst load", load, 0);
        check("rst setting", setting, 0);
        check("rst blink_h", blink_hours, 0);
        check("rst blink_m", blink_mins, 0);
        check("rst set", {set_hora_d, set_hora_u, set_min_d, set_min_u}, 16'h0000);
        reset = 1'b0;
        tick(2);

        // 1: basic edit 12:34 -> 14:34, press latency and blink phase
        set_cur(16'h1234);
        btn_mode = 1'b1;
        tick(7);
        check("t1 before_latency", setting, 0);
        tick(1);
        check("t1 setting", setting, 1);
        check("t1 blink_h_entry", blink_hours, 0);
        tick(5);
        check("t1 blink_h_toggle", blink_hours, 1);
        check("t1 blink_m_in_h", blink_mins, 0);
        btn_mode = 1'b0;
        tick(8);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("t1 blink_h_in_m", blink_hours, 0);
        check("t1 blink_m", blink_mins, 1);
        commit_expect("t1", 16'h1434);
        check("t1 set_hold", {set_hora_d, set_hora_u, set_min_d, set_min_u}, 16'h1434);
        check("t1 load_low", load, 0);
        check("t1 back_run", setting, 0);

        // 2: wrap boundaries, BCD carry, sanitising
        set_cur(16'h2359);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        commit_expect("t2 wrap", 16'h0000);

        set_cur(16'h0909);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        commit_expect("t2 carry", 16'h1010);

        set_cur(16'h2359);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        commit_expect("t2 max_valid", 16'h2359);

        set_cur(16'h2400);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        commit_expect("t2 bad_hours", 16'h0000);

        set_cur(16'h1965);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        commit_expect("t2 bad_mins", 16'h0100);

        // 3: glitch rejection in SET_M
        set_cur(16'h1234);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        btn_inc = 1'b1;
        tick(2);
        btn_inc = 1'b0;
        tick(12);
        press(1'b0, 1'b1);
        commit_expect("t3", 16'h1235);

        // 4: timeout abandons the edit; inc in RUN is ignored
        set_cur(16'h1234);
        lc = load_cnt;
        btn_mode = 1'b1;
        tick(8);
        btn_mode = 1'b0;
        tick(29);
        check("t4 before_timeout", setting, 1);
        tick(1);
        check("t4 timeout", setting, 0);
        check("t4 no_load", load_cnt - lc, 0);
        press(1'b0, 1'b1);
        check("t4 inc_in_run", setting, 0);

        // 5: simultaneous presses, then reset during SET_M
        set_cur(16'h1234);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check("t5 in_set_m", setting, 1);
        check("t5 blink_h_off", blink_hours, 0);
        commit_expect("t5 mode_wins", 16'h1234);

        set_cur(16'h0815);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("t5 pre_reset", setting, 1);
        lc = load_cnt;
        reset = 1'b1;
        tick(1);
        check("t5 rst setting", setting, 0);
        check("t5 rst load", load, 0);
        check("t5 rst blink", {blink_hours, blink_mins}, 0);
        check("t5 rst set", {set_hora_d, set_hora_u, set_min_d, set_min_u}, 16'h0000);
        reset = 1'b0;
        tick(10);
        check("t5 stays_run", setting, 0);
        check("t5 no_load", load_cnt - lc, 0);

`ifdef AUTO_REPEAT_EN
        // 6: held inc -> one press plus three repeats
        set_cur(16'h1234);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        btn_inc = 1'b1;
        tick(45);
        btn_inc = 1'b0;
        tick(10);
        commit_expect("t6 repeat", 16'h1238);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
